// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the push-button front-end.
//   code_width(n) : width of a priority code for n buttons (0 = none, 1..n).
//   CODE_NONE     : priority code meaning "no button held".
//   btn_event_t   : one event as carried by the event stream {code, repeat}.
package btn_pkg;

  localparam int CODE_NONE = 0;

  // Largest supported button count is 15, so codes always fit in 4 bits.
  localparam int CODE_MAX_W = 4;

  typedef struct packed {
    logic [CODE_MAX_W-1:0] code;
    logic                  is_repeat;
  } btn_event_t;

  function automatic int code_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser plus debounce filter for a single button.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   raw         : raw asynchronous button level, 1 = pressed
//   stable_next : debounced level as it will be registered on the next edge;
//                 exposing the next value lets the parent register its
//                 priority code on the same edge the level is accepted.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable_next
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   stable_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   level;

  assign level = sync_reg[SYNC_STAGES-1];

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample (a bounce back) restarts the count from zero.
  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    if (level != stable_reg) begin
      if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_next = level;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg   <= '0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], raw};
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

endmodule

// File: rtl/button_events.sv
// button_events: debounced push-button front-end with priority code and a
// one-entry valid/ready event stream of press and auto-repeat events.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   btn_raw     : raw asynchronous button levels, 1 = pressed
//   code        : registered priority code of the held button (0 = none)
//   ev_valid    : event available
//   ev_ready    : consumer accepts the event when ev_valid && ev_ready
//   ev_code     : code of the held event (never 0 while ev_valid)
//   ev_repeat   : 0 = press event, 1 = auto-repeat event
//   ev_overflow : sticky flag, set when an event had to be dropped
module button_events
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_BTN-1:0]             btn_raw,
  output logic [code_width(NUM_BTN)-1:0] code,
  output logic                           ev_valid,
  input  logic                           ev_ready,
  output logic [code_width(NUM_BTN)-1:0] ev_code,
  output logic                           ev_repeat,
  output logic                           ev_overflow
);

  localparam int CW      = code_width(NUM_BTN);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [NUM_BTN-1:0] stable_next;
  logic [CW-1:0]      code_reg;
  logic [CW-1:0]      code_next;
  logic [RPT_W-1:0]   rpt_cnt_reg;
  logic               rpt_phase_reg;   // 0 = waiting for first repeat, 1 = periodic
  logic               press_ev;
  logic               rpt_fire;
  logic               new_valid;
  btn_event_t         new_ev;
  btn_event_t         ev_reg;
  logic               ev_valid_reg;
  logic               ev_overflow_reg;
  logic               code_spare_unused;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .raw        (btn_raw[gi]),
        .stable_next(stable_next[gi])
      );
    end
  endgenerate

  // Priority encoder: scanning from the top down leaves the lowest index.
  always_comb begin
    code_next = CW'(CODE_NONE);
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (stable_next[i]) begin
        code_next = CW'(i + 1);
      end
    end
  end

  // A press covers any change to a non-zero code, including takeovers.
  // Repeats only fire while the held code is unchanged, so the two never
  // coincide.
  always_comb begin
    press_ev = (code_next != code_reg) && (code_next != CW'(CODE_NONE));
    rpt_fire = 1'b0;
    if ((REPEAT_PERIOD != 0) && (code_reg != CW'(CODE_NONE)) && (code_next == code_reg)) begin
      if (rpt_phase_reg) begin
        rpt_fire = (rpt_cnt_reg == RPT_W'(REPEAT_PERIOD - 1));
      end else begin
        rpt_fire = (rpt_cnt_reg == RPT_W'(REPEAT_DELAY - 1));
      end
    end
    new_valid        = press_ev || rpt_fire;
    new_ev.code      = CODE_MAX_W'(code_next);
    new_ev.is_repeat = !press_ev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_reg        <= '0;
      rpt_cnt_reg     <= '0;
      rpt_phase_reg   <= 1'b0;
      ev_reg          <= '0;
      ev_valid_reg    <= 1'b0;
      ev_overflow_reg <= 1'b0;
    end else begin
      code_reg <= code_next;

      if (code_next != code_reg) begin
        rpt_cnt_reg   <= '0;
        rpt_phase_reg <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt_reg   <= '0;
        rpt_phase_reg <= 1'b1;
      end else if (code_reg != CW'(CODE_NONE)) begin
        rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
      end

      // Loading while the held entry is being accepted loses nothing.
      if (new_valid && (!ev_valid_reg || ev_ready)) begin
        ev_reg       <= new_ev;
        ev_valid_reg <= 1'b1;
      end else if (new_valid) begin
        ev_overflow_reg <= 1'b1;
      end else if (ev_ready) begin
        ev_valid_reg <= 1'b0;
      end
    end
  end

  // Code bits above CW are always zero; fold them into a sink.
  assign code_spare_unused = ^ev_reg.code;

  assign code        = code_reg;
  assign ev_valid    = ev_valid_reg;
  assign ev_code     = ev_reg.code[CW-1:0];
  assign ev_repeat   = ev_reg.is_repeat;
  assign ev_overflow = ev_overflow_reg;

endmodule

// File: tb/tb_button_events.sv
module tb_button_events;

  localparam int NB = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [CW-1:0] code;
  logic          ev_valid;
  logic          ev_ready;
  logic [CW-1:0] ev_code;
  logic          ev_repeat;
  logic          ev_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_events #(
    .NUM_BTN        (NB),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .code       (code),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_repeat  (ev_repeat),
    .ev_overflow(ev_overflow)
  );

  typedef struct {
    logic [NB-1:0] btn;
    logic          ready;
    int            code;
    int            valid;
    int            ecode;
    int            erep;
    int            ovf;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One line per transaction; event fields only compared while ev_valid is expected.
  task automatic check_out(input string tag, input int c, input int v,
                           input int ec, input int er, input int ov);
    $display("%s: code=%0d valid=%0d ev_code=%0d rep=%0d ovf=%0d",
             tag, code, ev_valid, ev_code, ev_repeat, ev_overflow);
    chk({tag, " code"}, int'(code), c);
    chk({tag, " ev_valid"}, int'(ev_valid), v);
    if (v != 0) begin
      chk({tag, " ev_code"}, int'(ev_code), ec);
      chk({tag, " ev_repeat"}, int'(ev_repeat), er);
    end
    chk({tag, " ev_overflow"}, int'(ev_overflow), ov);
  endtask

  initial begin
    // Clean press of button 2 for 7 edges, then release; edge n is row n-1.
    for (int i = 0; i < 15; i++) begin
      tbl[i].btn   = (i < 7) ? 4'b0100 : 4'b0000;
      tbl[i].ready = 1'b1;
      tbl[i].code  = (i >= 5 && i <= 11) ? 3 : 0;
      tbl[i].valid = (i == 5) ? 1 : 0;
      tbl[i].ecode = 3;
      tbl[i].erep  = 0;
      tbl[i].ovf   = 0;
    end

    reset    = 1'b1;
    btn_raw  = '0;
    ev_ready = 1'b1;
    repeat (3) step();
    check_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      btn_raw  = tbl[i].btn;
      ev_ready = tbl[i].ready;
      step();
      check_out($sformatf("press2 e%0d", i + 1), tbl[i].code, tbl[i].valid,
                tbl[i].ecode, tbl[i].erep, tbl[i].ovf);
    end

    // Bouncing button 1: runs of 2 samples never reach 4.
    for (int k = 0; k < 10; k++) begin
      btn_raw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      for (int j = 0; j < 2; j++) begin
        step();
        check_out($sformatf("bounce k%0d", k), 0, 0, 0, 0, 0);
      end
    end
    btn_raw = 4'b0010;
    for (int e = 1; e <= 6; e++) begin
      step();
      check_out($sformatf("settle1 e%0d", e), (e == 6) ? 2 : 0, (e == 6) ? 1 : 0, 2, 0, 0);
    end
    btn_raw = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      step();
      check_out($sformatf("release1 e%0d", e), (e == 6) ? 0 : 2, 0, 0, 0, 0);
    end

    // Auto-repeat of button 3: press at edge 6, repeats at 14, 17, 20, ...
    btn_raw = 4'b1000;
    for (int e = 1; e <= 36; e++) begin
      step();
      check_out($sformatf("repeat3 e%0d", e), (e >= 6) ? 4 : 0,
                ((e == 6) || (e >= 14 && (e - 14) % 3 == 0)) ? 1 : 0,
                4, (e >= 14) ? 1 : 0, 0);
    end

    // Takeover by button 0 while 3 is held, then hand-back to 3.
    btn_raw = 4'b1001;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e < 6) chk($sformatf("take0 e%0d code", e), int'(code), 4);
      else check_out("take0 e6", 1, 1, 1, 0, 0);
    end
    btn_raw = 4'b1000;
    for (int e = 1; e <= 6; e++) begin
      step();
      check_out($sformatf("back3 e%0d", e), (e == 6) ? 4 : 1, (e == 6) ? 1 : 0, 4, 0, 0);
    end
    for (int e = 1; e <= 8; e++) begin
      step();
      check_out($sformatf("rerpt3 e%0d", e), 4, (e == 8) ? 1 : 0, 4, 1, 0);
    end

    // Backpressure: press held while two repeats are dropped.
    btn_raw = '0;
    reset   = 1'b1;
    repeat (2) step();
    reset    = 1'b0;
    ev_ready = 1'b0;
    btn_raw  = 4'b1000;
    for (int e = 1; e <= 19; e++) begin
      step();
      check_out($sformatf("stall e%0d", e), (e >= 6) ? 4 : 0, (e >= 6) ? 1 : 0,
                4, 0, (e >= 14) ? 1 : 0);
    end
    ev_ready = 1'b1;   // edge 20 also carries a repeat
    step();
    check_out("unstall e20", 4, 1, 4, 1, 1);
    step();
    check_out("unstall e21", 4, 0, 4, 1, 1);

    // Switch to button 2, then reset mid-operation with it held.
    btn_raw = 4'b0100;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) check_out("swap2 e6", 3, 1, 3, 0, 1);
    end
    reset = 1'b1;
    step();
    check_out("midreset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check_out($sformatf("postreset e%0d", e), (e == 6) ? 3 : 0, (e == 6) ? 1 : 0, 3, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Parametrised button front-end that replaces the single-cycle, undebounced priority register for the board push-buttons. It takes NUM_BTN raw asynchronous button inputs and synchronises and debounces each one. It drives a registered priority code of the held button, plus a valid/ready event stream carrying press and auto-repeat events for the game/menu control logic.

## Interface
Parameters:
- NUM_BTN, 4: number of buttons (1..15); index 0 has highest priority.
- SYNC_STAGES, 2: synchroniser flops per button (>=2).
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a change (>=1; 10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles from press event to first repeat event (>=1).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat events; 0 disables auto-repeat.

Ports (CW = clog2(NUM_BTN+1)):
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- code  out  CW  held-button priority code: 0 = none, i+1 = button i is the lowest-index debounced-pressed button.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event when ev_valid && ev_ready.
- ev_code  out  CW  code of the event (never 0).
- ev_repeat  out  1  0 = press event, 1 = auto-repeat event.
- ev_overflow  out  1  sticky: an event was dropped.

## Operation
- Per button: SYNC_STAGES-flop synchroniser, then debounce. While the synchronised level differs from the stable level, the counter increments. It clears whenever they match. On the DEBOUNCE_CYCLES-th consecutive differing sample, the stable level takes the new value and the counter clears.
- Priority: code_next = i+1 for the lowest i with stable[i] = 1, else 0. code is a register.
- Press event: generated in the cycle code_next != code and code_next != 0. This covers a new press, and a higher- or lower-priority takeover while another button is still held. A release to 0 generates no event.
- Repeat counter: clears on every code change. It counts while code != 0 and is unchanged. A repeat event fires when the count reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that. There are no repeats if REPEAT_PERIOD = 0.
- Event register, one entry:
  - A new event loads when !ev_valid, or when ev_valid && ev_ready in the same cycle (no loss).
  - If ev_valid && !ev_ready, the new event is dropped, the held event is unchanged, and ev_overflow is set.
  - ev_valid clears on acceptance when no new event arrives in that cycle.
- ev_code and ev_repeat are stable while ev_valid && !ev_ready.
- ev_overflow clears only on reset.

## Timing
- Reset values: all synchroniser flops, stable levels and counters are 0; code = 0, ev_valid = 0, ev_code = 0, ev_repeat = 0, ev_overflow = 0.
- Press latency: counting the first rising edge that samples btn_raw at its new level as edge 1, code and ev_valid become high after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is identical, for code only.
- A bounce, meaning a return to the old level at any sample before the DEBOUNCE_CYCLES-th, restarts the count.
- The first repeat is visible REPEAT_DELAY cycles after the press event's ev_valid rise. Subsequent repeats follow every REPEAT_PERIOD cycles, independent of ev_ready.
- Reset asserted mid-operation clears everything within one edge. A button held through reset is reported as a new press after the full press latency from reset deassertion.
- Simultaneous debounced presses in one cycle produce one event, with the lowest index.

## Structure
- Package btn_pkg: the code_width(NUM_BTN) function, CODE_NONE = 0, and an event struct {code, repeat}.
- Sub-module btn_debounce: synchroniser plus debounce counter for one button. It is instantiated NUM_BTN times with generate. The top level holds the priority encoder, the repeat counter and the event register.

## Test plan
All scenarios use NUM_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, ev_ready=1 unless stated.
- Clean press of btn_raw[2] -> code=3 and a single-cycle ev_valid with ev_code=3, ev_repeat=0 after edge 6. Release -> code=0 after edge 6, no event.
- btn_raw[1] toggling every 2 cycles for 20 cycles, then held -> no code change or events during toggling; code=2 exactly 6 edges after the final transition.
- Hold btn_raw[3] for 30 cycles after acceptance -> press at t0, then repeats (ev_repeat=1, ev_code=4) at t0+8, t0+11, t0+14 and so on.
- btn_raw[3] held, then btn_raw[0] pressed -> code 4 to 1 with a press event ev_code=1. Release btn_raw[0] -> code=4 with a press event ev_code=4 and the repeat counter restarted.
- ev_ready=0 through a press and two repeats -> ev_valid held with ev_code=4, ev_repeat=0 and ev_overflow=1. Raise ev_ready in a cycle that also generates a repeat -> the held press is accepted and the repeat loads the next cycle, with no drop.
- reset pulse while btn_raw[2] is held and code=3 -> all outputs 0 on the next edge; code=3 and a press event after 6 edges following deassertion.
